// File: rtl/parity_scan_pkg.sv
// ============================================================================
// parity_scan_pkg : shared state encoding, parity-mode and word-field constants
// Revision 1.0
// ============================================================================
`default_nettype none

package parity_scan_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SCAN  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic MODE_EVEN = 1'b0;
    localparam logic MODE_ODD  = 1'b1;

    // Stored word layout: data in [DATA_W:DATA_LSB], parity in [PAR_IDX]
    localparam int PAR_IDX  = 0;
    localparam int DATA_LSB = 1;

endpackage

`default_nettype wire

// File: rtl/parity_word_check.sv
// ============================================================================
// parity_word_check : combinational parity check of one stored word
// Revision 1.0
// ============================================================================
`default_nettype none

module parity_word_check
    import parity_scan_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W:0] word,
    input  logic            odd,
    output logic            ok
);

    logic w_data_xor;
    logic w_par;

    assign w_data_xor = ^word[DATA_W:DATA_LSB];
    assign w_par      = word[PAR_IDX];
    assign ok         = (odd == MODE_ODD) ? (w_data_xor != w_par)
                                          : (w_data_xor == w_par);

endmodule

`default_nettype wire

// File: rtl/parity_scan_engine.sv
// ============================================================================
// parity_scan_engine : walks a word memory and reports per-word parity results
// Revision 1.0
// ============================================================================
`default_nettype none

module parity_scan_engine
    import parity_scan_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              odd_mode,
    input  logic              stop_on_err,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W:0]   mem_rdata,
    output logic              busy,
    output logic              chk_valid,
    output logic              chk_ok,
    output logic [ADDR_W-1:0] chk_addr,
    output logic [CNT_W-1:0]  err_count,
    output logic              err_flag,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic              done
);

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic              r_odd;
    logic              r_stop;
    logic              r_rd_valid;
    logic [ADDR_W-1:0] r_rd_addr;
    logic              r_chk_valid;
    logic              r_chk_ok;
    logic [ADDR_W-1:0] r_chk_addr;
    logic [CNT_W-1:0]  r_err_count;
    logic [ADDR_W-1:0] r_first_err;
    logic              r_done;

    logic w_ok;
    logic w_fail;
    logic w_stop;
    logic w_start;
    logic w_last_addr;

    parity_word_check #(
        .DATA_W (DATA_W)
    ) u_check (
        .word (mem_rdata),
        .odd  (r_odd),
        .ok   (w_ok)
    );

    assign w_fail      = r_rd_valid && !w_ok;
    assign w_stop      = w_fail && r_stop && (r_state == ST_SCAN);
    assign w_start     = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_last_addr = (r_addr == ADDR_W'(DEPTH - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_odd       <= MODE_EVEN;
            r_stop      <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_rd_addr   <= '0;
            r_chk_valid <= 1'b0;
            r_chk_ok    <= 1'b0;
            r_chk_addr  <= '0;
            r_err_count <= '0;
            r_first_err <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done      <= 1'b0;
            r_chk_valid <= r_rd_valid;
            r_chk_ok    <= r_rd_valid && w_ok;
            if (r_rd_valid) begin
                r_chk_addr <= r_rd_addr;
            end
            // A read issued in the cycle that triggers an early stop is dropped here
            r_rd_valid <= (r_state == ST_SCAN) && !w_stop;
            r_rd_addr  <= r_addr;

            if (w_fail) begin
                r_err_count <= r_err_count + CNT_W'(1);
                if (r_err_count == '0) begin
                    r_first_err <= r_rd_addr;
                end
            end

            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_start) begin
                        r_state     <= ST_SCAN;
                        r_addr      <= '0;
                        r_odd       <= odd_mode;
                        r_stop      <= stop_on_err;
                        r_err_count <= '0;
                        r_first_err <= '0;
                    end
                end
                ST_SCAN: begin
                    if (w_stop) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                        r_addr  <= '0;
                    end else if (w_last_addr) begin
                        r_state <= ST_DRAIN;
                        r_addr  <= '0;
                    end else begin
                        r_addr <= r_addr + ADDR_W'(1);
                    end
                end
                ST_DRAIN: begin
                    r_state <= ST_DONE;
                    r_done  <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_en         = (r_state == ST_SCAN);
    assign mem_addr       = r_addr;
    assign busy           = (r_state == ST_SCAN) || (r_state == ST_DRAIN) || r_done;
    assign chk_valid      = r_chk_valid;
    assign chk_ok         = r_chk_ok;
    assign chk_addr       = r_chk_addr;
    assign err_count      = r_err_count;
    assign err_flag       = (r_err_count != '0);
    assign first_err_addr = r_first_err;
    assign done           = r_done;

endmodule

`default_nettype wire

// File: tb/tb_parity_scan_engine.sv
// ============================================================================
// tb_parity_scan_engine : table-driven and randomized checks of parity_scan_engine
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_parity_scan_engine;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       odd_mode = 1'b0;
    logic       stop_on_err = 1'b0;
    logic       mem_en;
    logic [3:0] mem_addr;
    logic [8:0] mem_rdata = '0;
    logic       busy, chk_valid, chk_ok, err_flag, done;
    logic [3:0] chk_addr, first_err_addr;
    logic [4:0] err_count;

    logic        start8 = 1'b0;
    logic        odd8 = 1'b0;
    logic        stop8 = 1'b0;
    logic        mem_en8;
    logic [2:0]  mem_addr8;
    logic [16:0] mem_rdata8 = '0;
    logic        busy8, chk_valid8, chk_ok8, err_flag8, done8;
    logic [2:0]  chk_addr8, first_err_addr8;
    logic [3:0]  err_count8;

    logic [8:0]  mem  [16];
    logic [16:0] mem8 [8];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en)  mem_rdata  <= mem[mem_addr];
        if (mem_en8) mem_rdata8 <= mem8[mem_addr8];
    end

    parity_scan_engine dut (
        .clk(clk), .reset(reset), .start(start), .odd_mode(odd_mode),
        .stop_on_err(stop_on_err), .mem_en(mem_en), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .busy(busy), .chk_valid(chk_valid), .chk_ok(chk_ok),
        .chk_addr(chk_addr), .err_count(err_count), .err_flag(err_flag),
        .first_err_addr(first_err_addr), .done(done)
    );

    parity_scan_engine #(.DATA_W(16), .DEPTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .odd_mode(odd8),
        .stop_on_err(stop8), .mem_en(mem_en8), .mem_addr(mem_addr8),
        .mem_rdata(mem_rdata8), .busy(busy8), .chk_valid(chk_valid8), .chk_ok(chk_ok8),
        .chk_addr(chk_addr8), .err_count(err_count8), .err_flag(err_flag8),
        .first_err_addr(first_err_addr8), .done(done8)
    );

    typedef struct {
        int cyc;
        int addr;
        bit ok;
    } ev_t;

    typedef struct {
        logic [15:0] bad_mask;
        bit          odd;
        bit          stop;
        int          poke;
        int          exp_cnt;
        int          exp_first;
        int          exp_n;
        int          exp_done;
    } vec_t;

    ev_t  got_q[$];
    ev_t  exp_q[$];
    int   got_done;
    int   m_cnt, m_first, m_done;
    int   n_chk = 0;
    int   n_err = 0;
    vec_t vecs[8];

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic load_mem(input logic [15:0] bad_mask);
        for (int a = 0; a < 16; a++) begin
            logic [7:0] d;
            d = 8'(a * 37 + 5);
            mem[a] = {d, (^d) ^ bad_mask[a]};
        end
    endtask

    // Reference: walk words in order, apply the parity rule, stop after first failure if asked
    task automatic model(input bit odd, input bit stop);
        exp_q.delete();
        m_cnt = 0; m_first = 0; m_done = -1;
        for (int a = 0; a < 16; a++) begin
            bit ok;
            ok = (((^mem[a][8:1]) ^ mem[a][0]) == odd);
            exp_q.push_back('{a + 3, a, ok});
            m_done = a + 3;
            if (!ok) begin
                if (m_cnt == 0) m_first = a;
                m_cnt++;
                if (stop) break;
            end
        end
    endtask

    task automatic run_scan(input bit odd, input bit stop, input int poke);
        @(negedge clk);
        odd_mode = odd; stop_on_err = stop; start = 1'b1;
        got_q.delete();
        got_done = -1;
        for (int c = 1; c <= 60 && got_done < 0; c++) begin
            @(posedge clk); #1;
            start = (c == poke);
            odd_mode = ~odd;
            stop_on_err = ~stop;
            if (c == 1) begin
                check("cycle1_busy", busy, 1);
                check("cycle1_mem_en", mem_en, 1);
                check("cycle1_mem_addr", mem_addr, 0);
            end
            if (chk_valid) got_q.push_back('{c, int'(chk_addr), chk_ok});
            if (done) got_done = c;
        end
        start = 1'b0;
        @(posedge clk); #1;
        check("busy_after_done", busy, 0);
        check("done_one_cycle", done, 0);
        check("no_chk_after_done", chk_valid, 0);
    endtask

    task automatic compare(input string tag);
        int n;
        check({tag, "_nchk"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_ev%0d_cyc", tag, i), got_q[i].cyc, exp_q[i].cyc);
            check($sformatf("%s_ev%0d_addr", tag, i), got_q[i].addr, exp_q[i].addr);
            check($sformatf("%s_ev%0d_ok", tag, i), got_q[i].ok, exp_q[i].ok);
        end
        check({tag, "_done_cyc"}, got_done, m_done);
        check({tag, "_err_count"}, err_count, m_cnt);
        check({tag, "_err_flag"}, err_flag, m_cnt != 0);
        check({tag, "_first_err"}, first_err_addr, m_first);
    endtask

    initial begin
        vecs[0] = '{16'h0000, 1'b0, 1'b0, -1,  0,  0, 16, 18};
        vecs[1] = '{16'h0808, 1'b0, 1'b0, -1,  2,  3, 16, 18};
        vecs[2] = '{16'h0808, 1'b1, 1'b0, -1, 14,  0, 16, 18};
        vecs[3] = '{16'h0020, 1'b0, 1'b1, -1,  1,  5,  6,  8};
        vecs[4] = '{16'h0000, 1'b1, 1'b1, -1,  1,  0,  1,  3};
        vecs[5] = '{16'h8000, 1'b0, 1'b1, -1,  1, 15, 16, 18};
        vecs[6] = '{16'h4000, 1'b0, 1'b1, -1,  1, 14, 15, 17};
        vecs[7] = '{16'h0808, 1'b0, 1'b0,  4,  2,  3, 16, 18};

        load_mem(16'h0000);
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", busy, 0);
        check("reset_mem_en", mem_en, 0);
        check("reset_mem_addr", mem_addr, 0);
        check("reset_chk_valid", chk_valid, 0);
        check("reset_err_count", err_count, 0);
        check("reset_first_err", first_err_addr, 0);
        check("reset_done", done, 0);
        @(negedge clk);
        reset = 1'b0;

        for (int v = 0; v < 8; v++) begin
            string tag;
            tag = $sformatf("vec%0d", v);
            load_mem(vecs[v].bad_mask);
            run_scan(vecs[v].odd, vecs[v].stop, vecs[v].poke);
            check({tag, "_tbl_nchk"}, got_q.size(), vecs[v].exp_n);
            check({tag, "_tbl_done"}, got_done, vecs[v].exp_done);
            check({tag, "_tbl_cnt"}, err_count, vecs[v].exp_cnt);
            check({tag, "_tbl_first"}, first_err_addr, vecs[v].exp_first);
            model(vecs[v].odd, vecs[v].stop);
            compare(tag);
            repeat (3) @(posedge clk);
            #1;
            check({tag, "_hold_cnt"}, err_count, vecs[v].exp_cnt);
            check({tag, "_hold_first"}, first_err_addr, vecs[v].exp_first);
        end

        for (int r = 0; r < 20; r++) begin
            bit ro, rs;
            for (int a = 0; a < 16; a++) mem[a] = 9'($urandom);
            ro = 1'($urandom);
            rs = ($urandom_range(0, 3) == 0);
            run_scan(ro, rs, -1);
            model(ro, rs);
            compare($sformatf("rnd%0d", r));
        end

        // Asynchronous reset in cycle 8 of a scan, then a clean restart
        load_mem(16'h0808);
        @(negedge clk);
        odd_mode = 1'b0; stop_on_err = 1'b0; start = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        check("pre_reset_err_count", err_count, 1);
        reset = 1'b1;
        #1;
        check("async_busy", busy, 0);
        check("async_mem_en", mem_en, 0);
        check("async_err_count", err_count, 0);
        check("async_err_flag", err_flag, 0);
        check("async_first_err", first_err_addr, 0);
        check("async_chk_valid", chk_valid, 0);
        @(negedge clk);
        reset = 1'b0;
        run_scan(1'b0, 1'b0, -1);
        model(1'b0, 1'b0);
        compare("restart");

        // Narrower-depth, wider-data instance with word 2 corrupted
        for (int a = 0; a < 8; a++) begin
            logic [15:0] d;
            d = 16'(a * 4099 + 77);
            mem8[a] = {d, (^d) ^ (a == 2)};
        end
        begin
            int n8, d8, c8;
            n8 = 0; d8 = -1; c8 = 0;
            @(negedge clk);
            start8 = 1'b1;
            while (d8 < 0 && c8 < 40) begin
                @(posedge clk); #1;
                c8++;
                start8 = 1'b0;
                if (chk_valid8) n8++;
                if (done8) d8 = c8;
            end
            check("d8_done_cyc", d8, 10);
            check("d8_nchk", n8, 8);
            check("d8_err_count", err_count8, 1);
            check("d8_first_err", first_err_addr8, 2);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/parity_scan_engine.md
# parity_scan_engine

Parametrised parity scanner: on a start pulse it walks every address of an attached word memory, checks each word's stored parity bit against its data in even or odd mode, and reports per-word results, an error count and the first failing address. It replaces the fixed 8-bit, 16-address counter, ROM and checker chain as the self-test block between the word store and the status logic. Scans are restartable. An optional stop-on-first-error mode ends a scan early.

## Interface
- DATA_W, 8: data bits per word; a stored word is DATA_W+1 bits, with data in [DATA_W:1] and parity in [0].
- DEPTH, 16: number of words scanned, addresses 0..DEPTH-1; must be at least 2.
- ADDR_W, clog2(DEPTH): address width (derived).
- CNT_W, clog2(DEPTH+1): error-count width (derived).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- start  in  1  scan request; sampled only in IDLE or DONE.
- odd_mode  in  1  0 = even parity, 1 = odd parity; latched at start.
- stop_on_err  in  1  end the scan at the first failing word; latched at start.
- mem_en  out  1  read strobe.
- mem_addr  out  ADDR_W  read address.
- mem_rdata  in  DATA_W+1  read data; valid the cycle after mem_en.
- busy  out  1  high from the cycle after start until the done cycle, inclusive.
- chk_valid  out  1  one-cycle strobe per checked word.
- chk_ok  out  1  parity result for that word; valid with chk_valid.
- chk_addr  out  ADDR_W  address of that word.
- err_count  out  CNT_W  number of failing words in the current or last scan.
- err_flag  out  1  high if err_count is nonzero.
- first_err_addr  out  ADDR_W  address of the first failure; 0 if there was none.
- done  out  1  one-cycle pulse at the end of the scan.

## Operation
- Word check:
  - Even mode: a word is ok when the XOR of its data bits equals the parity bit.
  - Odd mode: a word is ok when that XOR is not equal to the parity bit.
- FSM states: IDLE, SCAN, DRAIN, DONE.
- IDLE or DONE with start=1:
  - Go to SCAN.
  - Latch odd_mode and stop_on_err.
  - Clear err_count, err_flag and first_err_addr.
- SCAN:
  - mem_en=1.
  - mem_addr starts at 0 and increments by 1 each cycle.
  - After address DEPTH-1 is issued, go to DRAIN.
- DRAIN: mem_en=0; the last read completes.
- Each cycle in which read data is valid, the check result is registered and appears the next cycle on chk_valid, chk_ok and chk_addr.
- On a failing word:
  - err_count increments.
  - first_err_addr is captured only if err_count was 0.
- stop_on_err=1 with a failure in SCAN:
  - Go directly to DONE.
  - The read issued in the same cycle is discarded: it is not checked, counted or reported.
- DONE:
  - done pulses in the cycle carrying the final chk_valid.
  - The FSM holds there until the next start.
  - err_count, err_flag and first_err_addr hold until the next start or reset.
- start while busy is ignored. A start held high re-triggers a scan on each cycle it is sampled in DONE.
- err_count cannot overflow: CNT_W covers DEPTH failures.

## Timing
- Reset values: state IDLE; every output 0.
- start is high in cycle 0.
- Cycle 1: mem_en=1, mem_addr=0, busy=1.
- Cycle k+1: address k is issued.
- Cycle k+3: chk_valid for address k.
- Full scan: done and the last chk_valid (address DEPTH-1) occur in cycle DEPTH+2; busy falls in cycle DEPTH+3.
- Early stop on address k: done occurs in cycle k+3; no further chk_valid after it.
- Reset asserted mid-scan: all outputs return to reset values asynchronously; the next start after release runs a normal scan.

## Structure
- Package parity_scan_pkg holds:
  - the state encoding localparams (IDLE, SCAN, DRAIN, DONE);
  - the EVEN and ODD mode constants;
  - the word-field index constants.
- Sub-module parity_word_check (parameter DATA_W): combinational XOR reduction plus mode compare, giving ok. It is instantiated once.

## Test plan
- Defaults, all 16 words carry correct even parity, even mode, start pulse -> 16 chk_valid pulses with chk_ok=1, chk_addr 0..15, done in cycle 18, err_count=0, err_flag=0.
- Same memory with words 3 and 11 corrupted (parity bit flipped) -> chk_ok=0 at addresses 3 and 11, err_count=2, first_err_addr=3, err_flag=1.
- Same memory as the previous test, odd_mode=1 -> err_count=14, first_err_addr=0.
- stop_on_err=1 with only word 5 bad -> 6 chk_valid pulses (addresses 0..5), done in cycle 8 with chk_addr=5, err_count=1; address 6 is issued but never reported.
- reset asserted in cycle 8 of a scan -> busy, mem_en and err_count are 0 immediately; a restart completes normally with the correct err_count.
- start pulsed in cycle 4 of a scan -> ignored. A second start in DONE -> counters cleared and a full scan repeats. DATA_W=16, DEPTH=8 -> done in cycle 10.
